// File: rtl/vect_pkg.sv
// Shared constants and elaboration helpers for the vectorised lane aligner.
// Latency: none (package only).
// Backpressure: not applicable.
package vect_pkg;

    localparam int NLANES_DEF = 16;
    localparam int DATAW_DEF  = 32;
    localparam int DEPTH_DEF  = 4;

    function automatic int vect_clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Lane i occupies [lane_lsb(i) +: dataw] of every packed lane bus.
    function automatic int lane_lsb(input int lane, input int dataw);
        return lane * dataw;
    endfunction

endpackage

// File: rtl/vect_lane_fifo.sv
// Per-lane result FIFO, power-of-two depth, registered storage, no fall-through.
// Latency: a push at edge t is visible on dout/empty in cycle t+1.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module vect_lane_fifo
    import vect_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] din,
    output logic [DATAW-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = vect_clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/vect_lane_aligner.sv
// Broadcasts the vector handshake to NLANES kernels and re-aligns their results; VECT_ALIGN_STATS_EN adds stall counters.
// Latency: kernel latency + 1 (lane FIFOs are read from registered storage, no fall-through).
// Backpressure: credit counter caps in-flight vectors at DEPTH; oready=0 holds odata/ovalid until the pop.
module vect_lane_aligner
    import vect_pkg::*;
#(
    parameter int NLANES = NLANES_DEF,
    parameter int DATAW  = DATAW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid,
    output logic                     iready,
    input  logic [NLANES-1:0]        lane_mask,
    output logic                     lane_ivalid,
    input  logic [NLANES-1:0]        lane_iready,
    input  logic [NLANES-1:0]        lane_ovalid,
    input  logic [NLANES*DATAW-1:0]  lane_odata,
    output logic [NLANES-1:0]        lane_oready,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [NLANES*DATAW-1:0]  odata,
    output logic                     err
`ifdef VECT_ALIGN_STATS_EN
    ,
    output logic [31:0]              stall_in_cnt,
    output logic [31:0]              stall_out_cnt
`endif
);

    localparam int CW = vect_clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]     credit_q;
    logic [CW-1:0]     credit_d;
    logic [NLANES-1:0] mask_q;
    logic              run_q;
    logic              err_q;
    logic [NLANES-1:0] full;
    logic [NLANES-1:0] empty;
    logic [NLANES-1:0] push;
    logic [NLANES-1:0] pop;
    logic [DATAW-1:0]  head [NLANES];
    logic              in_fire;
    logic              out_fire;
    logic              overflow;

    // run_q keeps iready low while reset is applied, independent of lane_iready.
    assign iready      = run_q & (&(lane_iready | ~mask_q)) & (credit_q < DEPTH_C) & (|mask_q);
    assign ovalid      = (&(~empty | ~mask_q)) & (credit_q != '0);
    assign in_fire     = ivalid & iready;
    assign out_fire    = ovalid & oready;
    assign lane_ivalid = in_fire;
    assign lane_oready = ~full;
    assign push        = lane_ovalid & lane_oready & mask_q;
    assign pop         = {NLANES{out_fire}} & mask_q;
    assign overflow    = |(lane_ovalid & mask_q & full);
    assign err         = err_q;

    always_comb begin
        credit_d = credit_q;
        if (in_fire && !out_fire) begin
            credit_d = credit_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            credit_q <= '0;
            mask_q   <= '1;
            err_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            credit_q <= credit_d;
            if (credit_q == '0 && !in_fire) begin
                mask_q <= lane_mask;
            end
            if (overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        vect_lane_fifo #(
            .DATAW (DATAW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (lane_odata[lane_lsb(g, DATAW) +: DATAW]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );

        // Masked lanes and empty lanes present zero rather than stale storage.
        assign odata[lane_lsb(g, DATAW) +: DATAW] = (mask_q[g] && !empty[g]) ? head[g] : '0;
    end

`ifdef VECT_ALIGN_STATS_EN
    logic [31:0] stall_in_q;
    logic [31:0] stall_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            if (ivalid && !iready && stall_in_q != '1) begin
                stall_in_q <= stall_in_q + 32'd1;
            end
            if (ovalid && !oready && stall_out_q != '1) begin
                stall_out_q <= stall_out_q + 32'd1;
            end
        end
    end

    assign stall_in_cnt  = stall_in_q;
    assign stall_out_cnt = stall_out_q;
`endif

endmodule

// File: tb/tb_vect_lane_aligner.sv
// Randomised bench for vect_lane_aligner: kernel models with per-lane latency feed a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_vect_lane_aligner;

    localparam int NL = 16;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int PW = NL * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ivalid;
    logic          iready;
    logic [NL-1:0] lane_mask;
    logic          lane_ivalid;
    logic [NL-1:0] lane_iready;
    logic [NL-1:0] lane_ovalid;
    logic [PW-1:0] lane_odata;
    logic [NL-1:0] lane_oready;
    logic          ovalid;
    logic          oready;
    logic [PW-1:0] odata;
    logic          err;
`ifdef VECT_ALIGN_STATS_EN
    logic [31:0]   stall_in_cnt;
    logic [31:0]   stall_out_cnt;
    logic [31:0]   st_in;
    logic [31:0]   st_out;
`endif

    always #5 clk = ~clk;

    vect_lane_aligner #(.NLANES(NL), .DATAW(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .ivalid      (ivalid),
        .iready      (iready),
        .lane_mask   (lane_mask),
        .lane_ivalid (lane_ivalid),
        .lane_iready (lane_iready),
        .lane_ovalid (lane_ovalid),
        .lane_odata  (lane_odata),
        .lane_oready (lane_oready),
        .ovalid      (ovalid),
        .oready      (oready),
        .odata       (odata),
        .err         (err)
`ifdef VECT_ALIGN_STATS_EN
        ,
        .stall_in_cnt  (stall_in_cnt),
        .stall_out_cnt (stall_out_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: vectors in flight, per-lane buffered results, kernel pipelines.
    logic [PW-1:0] expq [$];
    logic [DW-1:0] mq   [NL][$];
    logic [DW-1:0] kq_d [NL][$];
    int            kq_t [NL][$];
    logic [NL-1:0] mask_m;
    logic          err_m;
    logic [NL-1:0] phase_mask;
    int            lat [NL];
    int            cyc = 0;
    int            iv_pct = 0;
    int            or_pct = 100;
    int            lr_pct = 100;
    int            first_in = -1;
    int            first_ov = -1;
    logic [PW-1:0] snap_od;
    logic          snap_ov;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit idle();
        if (expq.size() != 0) return 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (kq_d[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_lat(input int l);
        for (int i = 0; i < NL; i++) lat[i] = l;
    endtask

    task automatic step();
        logic [NL-1:0] e_lor;
        logic [NL-1:0] has;
        logic [PW-1:0] e_od;
        logic [PW-1:0] vec;
        logic [DW-1:0] d;
        logic          e_ir;
        logic          e_ov;
        logic          in_f;
        logic          out_f;
        int            credit;
        @(negedge clk);
        credit      = expq.size();
        ivalid      = ($urandom_range(99) < iv_pct);
        oready      = ($urandom_range(99) < or_pct);
        lane_iready = '1;
        if ($urandom_range(99) >= lr_pct) lane_iready[$urandom_range(NL-1)] = 1'b0;
        lane_mask   = (credit == 0) ? phase_mask : NL'($urandom);
        for (int i = 0; i < NL; i++) begin
            lane_ovalid[i] = (kq_t[i].size() > 0) && (kq_t[i][0] <= cyc);
            lane_odata[i*DW +: DW] = lane_ovalid[i] ? kq_d[i][0] : DW'($urandom);
        end
        e_ir = (&(lane_iready | ~mask_m)) && (credit < DP) && (mask_m != '0);
        e_od = '0;
        for (int i = 0; i < NL; i++) begin
            has[i]   = (mq[i].size() > 0) || !mask_m[i];
            e_lor[i] = (mq[i].size() < DP);
            if (mask_m[i] && mq[i].size() > 0) e_od[i*DW +: DW] = mq[i][0];
        end
        e_ov = (&has) && (credit != 0);
        #1;
        chk("iready", PW'(iready), PW'(e_ir));
        chk("ovalid", PW'(ovalid), PW'(e_ov));
        chk("lane_ivalid", PW'(lane_ivalid), PW'(ivalid & e_ir));
        chk("lane_oready", PW'(lane_oready), PW'(e_lor));
        chk("odata", odata, e_od);
        chk("err", PW'(err), PW'(err_m));
        in_f  = ivalid & e_ir;
        out_f = e_ov & oready;
        if (out_f) chk("vec_order", odata, (credit > 0) ? expq[0] : '0);
        if (in_f && first_in < 0) first_in = cyc;
        if (ovalid === 1'b1 && first_ov < 0) first_ov = cyc;
`ifdef VECT_ALIGN_STATS_EN
        chk("stall_in_cnt", PW'(stall_in_cnt), PW'(st_in));
        chk("stall_out_cnt", PW'(stall_out_cnt), PW'(st_out));
        if (ivalid && !e_ir) st_in = st_in + 32'd1;
        if (e_ov && !oready) st_out = st_out + 32'd1;
`endif
        @(posedge clk);
        for (int i = 0; i < NL; i++) begin
            if (out_f && mask_m[i]) void'(mq[i].pop_front());
            if (lane_ovalid[i] && mask_m[i]) begin
                if (e_lor[i]) mq[i].push_back(lane_odata[i*DW +: DW]);
                else          err_m = 1'b1;
            end
            if (lane_ovalid[i] && e_lor[i]) begin
                void'(kq_d[i].pop_front());
                void'(kq_t[i].pop_front());
            end
        end
        if (out_f) void'(expq.pop_front());
        if (credit == 0 && !in_f) mask_m = lane_mask;
        if (in_f) begin
            vec = '0;
            for (int i = 0; i < NL; i++) begin
                d = DW'($urandom);
                kq_d[i].push_back(d);
                kq_t[i].push_back(cyc + lat[i]);
                if (mask_m[i]) vec[i*DW +: DW] = d;
            end
            expq.push_back(vec);
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n      = 0;
        iv_pct = 0;
        or_pct = 100;
        while (!idle() && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", PW'(idle()), PW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst         = 1'b0;
        ivalid      = 1'b0;
        oready      = 1'b0;
        lane_ovalid = '0;
        lane_iready = '1;
        lane_mask   = '1;
        #1;
        chk("rst_iready", PW'(iready), PW'(0));
        chk("rst_ovalid", PW'(ovalid), PW'(0));
        chk("rst_odata", odata, '0);
        chk("rst_err", PW'(err), PW'(0));
        expq.delete();
        for (int i = 0; i < NL; i++) begin
            mq[i].delete();
            kq_d[i].delete();
            kq_t[i].delete();
        end
        mask_m = '1;
        err_m  = 1'b0;
`ifdef VECT_ALIGN_STATS_EN
        st_in  = '0;
        st_out = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        ivalid      = 1'b0;
        oready      = 1'b0;
        lane_iready = '1;
        lane_ovalid = '0;
        lane_odata  = '0;
        lane_mask   = '1;
        phase_mask  = '1;
        mask_m      = '1;
        err_m       = 1'b0;
        set_lat(3);
        do_reset();

        // Uniform latency 3: first result appears 4 cycles after the first accepted vector.
        repeat (2) step();
        first_in = -1;
        first_ov = -1;
        iv_pct = 100; or_pct = 100; lr_pct = 100;
        repeat (20) step();
        chk("lat_first_ovalid", PW'(first_ov - first_in), PW'(4));
        drain();

        // Unequal latency, then a long downstream stall.
        lat[0] = 1;
        lat[5] = 6;
        iv_pct = 100; or_pct = 0;
        repeat (6) step();
        #1;
        chk("unequal_credit_full_iready", PW'(iready), PW'(0));
        chk("unequal_err", PW'(err), PW'(0));
        repeat (10) step();
        #1;
        snap_od = odata;
        snap_ov = ovalid;
        chk("bp_ovalid", PW'(snap_ov), PW'(1));
        repeat (10) step();
        #1;
        chk("bp_odata_stable", odata, snap_od);
        chk("bp_ovalid_stable", PW'(ovalid), PW'(snap_ov));
        drain();

        // Ragged tail: only lanes 0-3 active, masked lanes deliberately slow.
        phase_mask = 16'h000F;
        for (int i = 0; i < NL; i++) lat[i] = (i < 4) ? 3 : 8;
        repeat (2) step();
        iv_pct = 100; or_pct = 0;
        repeat (10) step();
        #1;
        chk("ragged_hi_zero", odata >> 128, '0);
        chk("ragged_ovalid", PW'(ovalid), PW'(1));
        drain();

        for (int p = 0; p < 10; p++) begin
            drain();
            case (p % 3)
                0:       phase_mask = '1;
                1:       phase_mask = 16'h000F;
                default: phase_mask = NL'($urandom) | NL'(1);
            endcase
            for (int i = 0; i < NL; i++) lat[i] = $urandom_range(8, 1);
            iv_pct = $urandom_range(100, 30);
            or_pct = $urandom_range(100, 30);
            lr_pct = $urandom_range(100, 80);
            repeat (150) step();
        end
        drain();

        // Overflow: lane 2 emits five results with nothing in flight.
        phase_mask = '1;
        lr_pct = 100;
        repeat (2) step();
        for (int k = 0; k < 5; k++) begin
            kq_d[2].push_back(DW'($urandom));
            kq_t[2].push_back(cyc);
        end
        repeat (4) step();
        #1;
        chk("ovf_err_after4", PW'(err), PW'(0));
        repeat (2) step();
        #1;
        chk("ovf_err", PW'(err), PW'(1));
        chk("ovf_lane2_full", PW'(lane_oready[2]), PW'(0));

        // Reset with three vectors in flight.
        do_reset();
        set_lat(2);
        iv_pct = 100; or_pct = 0;
        begin
            int n;
            n = 0;
            while (expq.size() < 3 && n < 20) begin
                step();
                n++;
            end
        end
        iv_pct = 0;
        repeat (3) step();
        #1;
        chk("pre_rst_ovalid", PW'(ovalid), PW'(1));
        do_reset();
        repeat (3) step();
        #1;
        chk("post_rst_iready", PW'(iready), PW'(1));
        chk("post_rst_lane_oready", PW'(lane_oready), PW'({NL{1'b1}}));
        iv_pct = 100; or_pct = 100;
        repeat (20) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vect_lane_aligner.md
Name: vect_lane_aligner

Overview:
- Handshake and alignment block for NLANES-wide vectorised kernel lanes.
- Sits between the packed top-level streams and the per-lane kernelTop instances.
- Broadcasts the input handshake to all lanes and buffers each lane's output in a small FIFO. The packed output is presented only when every active lane has a result.
- Credit counter bounds in-flight items, so lanes with unequal latency or stalls never overflow. A lane mask supports a ragged final vector.

Parameters:
- NLANES, 16, number of lanes.
- DATAW, 32, per-lane data width.
- DEPTH, 4, per-lane FIFO depth; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ivalid  in  1  upstream vector valid.
- iready  out  1  upstream vector ready.
- lane_mask  in  NLANES  1 = lane active; sampled only when idle.
- lane_ivalid  out  1  broadcast valid to all lanes.
- lane_iready  in  NLANES  per-lane kernel ready.
- lane_ovalid  in  NLANES  per-lane kernel result valid.
- lane_odata  in  NLANES*DATAW  per-lane results; lane i at [i*DATAW +: DATAW].
- lane_oready  out  NLANES  per-lane FIFO not full.
- ovalid  out  1  packed output valid.
- oready  in  1  downstream ready.
- odata  out  NLANES*DATAW  packed output.
- err  out  1  sticky overflow error.

Behaviour:
- Reset (rst=0, asynchronous) puts the block in this state:
  - iready=0, ovalid=0, odata=0, err=0.
  - credit=0 and all FIFOs empty.
  - mask_q = all ones.
- Applying reset mid-operation flushes all in-flight state.
- mask_q loads from lane_mask on any cycle with credit==0 and no input fire. Otherwise lane_mask is ignored.
- Input side:
  - iready = (&(lane_iready | ~mask_q)) & (credit < DEPTH) & (|mask_q).
  - in_fire = ivalid & iready.
  - lane_ivalid = in_fire. Masked lanes still receive it; their results are dropped.
- Per-lane FIFO, active lanes:
  - Push when lane_ovalid[i] & lane_oready[i].
  - lane_oready[i] = ~full[i].
- Per-lane FIFO, masked lanes:
  - Never written.
  - Treated as non-empty for output purposes; contribute zero data.
- Output side:
  - ovalid = &(~empty | ~mask_q) & (credit != 0).
  - out_fire = ovalid & oready. On out_fire, every active FIFO pops simultaneously.
  - odata lane i = FIFO head when active, 0 when masked. It is a combinational read of the registered FIFO storage.
- Latency:
  - A lane result written at edge t is visible on odata/ovalid after edge t, i.e. in cycle t+1.
  - There is no fall-through in the same cycle.
  - Input-to-output latency = kernel latency + 1.
- Credit counter (width clog2(DEPTH)+1):
  - +1 on in_fire; −1 on out_fire; unchanged when both occur.
  - Never exceeds DEPTH and never underflows.
- Full FIFO with simultaneous push and pop: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH.
- Overflow: lane_ovalid[i] asserted on an active lane while full[i] sets err=1. It stays set until reset. The write is dropped and the count is unchanged. This is unreachable if kernels obey the credit protocol.
- Backpressure: oready=0 holds odata and ovalid stable until the pop.

Optional Feature:
- Macro: VECT_ALIGN_STATS_EN.
- With the macro defined, the block adds outputs stall_in_cnt[31:0] and stall_out_cnt[31:0]. Both reset to 0 and saturate at 0xFFFFFFFF.
  - stall_in_cnt increments each cycle with ivalid & ~iready.
  - stall_out_cnt increments each cycle with ovalid & ~oready.
- Without the macro, the ports and logic are absent; remaining behaviour is identical.

Decomposition:
- Shared package vect_pkg holds:
  - Default constants NLANES_DEF=16, DATAW_DEF=32, DEPTH_DEF=4.
  - A clog2 function.
  - The lane-slice width rule.
- One sub-module: vect_lane_fifo.
  - Parameters DATAW and DEPTH; ports push, pop, din, dout, full, empty.
  - Same clk/rst convention as the parent.
  - Instantiated NLANES times in a generate loop.

Test Plan:
- Basic flow: NLANES=16, mask all ones, kernels with latency 3, data lane i = 0x1000+i, oready=1 → ovalid first asserts 4 cycles after in_fire; odata lane i = 0x1000+i; one vector per cycle sustained.
- Unequal latency: lane 0 latency 1, lane 5 latency 6 → ovalid waits for lane 5. After the 4th in_fire with no out_fire, iready=0 (credit=4), err stays 0.
- Backpressure: oready=0 for 10 cycles mid-stream → odata stable, credit saturates at DEPTH=4, iready=0. On release, 4 vectors drain in order.
- Ragged tail: with idle (credit=0), lane_mask=0x000F → odata[511:128]=0; ovalid depends only on lanes 0–3. A lane_mask change during credit≠0 has no effect.
- Overflow injection: force lane 2 to assert lane_ovalid 5 times without pop → err=1 on the 5th, FIFO count stays 4.
- Reset mid-stream: assert rst=0 with credit=3 → ovalid and iready drop immediately; after release FIFOs are empty and credit=0. With VECT_ALIGN_STATS_EN, both counters read 0.
